// File: rtl/selftest_pkg.sv
// Shared constants and types for the self-test sequencer and its AXI4-Lite engine.
// SELFTEST_DIO_EN selects the full BRAM+DIO poll masks; otherwise BRAM-only masks.
package selftest_pkg;

  localparam logic [7:0] REG_CTRL_STATUS      = 8'd0;
  localparam logic [7:0] REG_DIO_SETTINGS     = 8'd12;
  localparam logic [7:0] REG_DIO_STATUS       = 8'd16;
  localparam logic [7:0] REG_BRAM_SEED        = 8'd24;
  localparam logic [7:0] REG_BRAM_ADDR_MAX    = 8'd28;
  localparam logic [7:0] REG_BRAM_STATUS      = 8'd32;
  localparam logic [7:0] REG_DIO_COUNTER_MAX  = 8'd36;
  localparam logic [7:0] REG_DIO_OUTPUT_PHASE = 8'd40;

`ifdef SELFTEST_DIO_EN
  localparam logic [31:0] RDY_MASK  = 32'h0000_01A4;
  localparam logic [31:0] DONE_MASK = 32'h0000_0048;
`else
  localparam logic [31:0] RDY_MASK  = 32'h0000_0020;
  localparam logic [31:0] DONE_MASK = 32'h0000_0040;
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_POLL_RDY,
    S_WR_ADDR_MAX,
    S_WR_SEED,
    S_WR_CMAX,
    S_WR_PHASE,
    S_WR_SETTINGS,
    S_POLL_DONE,
    S_RD_BRAM,
    S_RD_DIO,
    S_FINISH
  } seq_state_t;

  typedef enum logic [2:0] {
    ERR_OK       = 3'd0,
    ERR_BRESP    = 3'd1,
    ERR_RRESP    = 3'd2,
    ERR_RDY_TMO  = 3'd3,
    ERR_DONE_TMO = 3'd4
  } err_t;

  typedef enum logic [2:0] {
    M_IDLE,
    M_WRITE,
    M_WRESP,
    M_RADDR,
    M_RDATA
  } mst_state_t;

  typedef logic [1:0] resp_t;
  localparam resp_t RESP_OKAY = 2'b00;

endpackage

// File: rtl/axil_single_master.sv
// Single-transaction AXI4-Lite master: one read or write per req, ack pulses with
// the captured response (and read data) once the response channel handshakes.
module axil_single_master
  import selftest_pkg::*;
(
  input  logic        clk,
  input  logic        aresetn,
  input  logic        req,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic [1:0]  resp,
  output logic [7:0]  m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [7:0]  m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  mst_state_t  state_q, state_d;
  logic        aw_done_q, w_done_q;
  logic [7:0]  addr_q;
  logic [31:0] wdata_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= M_IDLE;
    else          state_q <= state_d;
  end

  // Write leaves M_WRITE only once both AW and W have handshaken, in any order.
  always_comb begin
    state_d = state_q;
    case (state_q)
      M_IDLE:  if (req) state_d = we ? M_WRITE : M_RADDR;
      M_WRITE: if ((aw_done_q || m_awready) && (w_done_q || m_wready)) state_d = M_WRESP;
      M_WRESP: if (m_bvalid) state_d = M_IDLE;
      M_RADDR: if (m_arready) state_d = M_RDATA;
      M_RDATA: if (m_rvalid) state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ack       <= 1'b0;
      rdata     <= '0;
      resp      <= RESP_OKAY;
    end else begin
      ack <= 1'b0;
      if (state_q == M_IDLE && req) begin
        addr_q    <= addr;
        wdata_q   <= wdata;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (state_q == M_WRITE) begin
        if (m_awready) aw_done_q <= 1'b1;
        if (m_wready)  w_done_q  <= 1'b1;
      end
      if (state_q == M_WRESP && m_bvalid) begin
        ack  <= 1'b1;
        resp <= m_bresp;
      end
      if (state_q == M_RDATA && m_rvalid) begin
        ack   <= 1'b1;
        resp  <= m_rresp;
        rdata <= m_rdata;
      end
    end
  end

  // Valids/readies decode straight from registers so reset drops them immediately.
  assign m_awaddr  = addr_q;
  assign m_araddr  = addr_q;
  assign m_wdata   = wdata_q;
  assign m_awvalid = (state_q == M_WRITE) && !aw_done_q;
  assign m_wvalid  = (state_q == M_WRITE) && !w_done_q;
  assign m_bready  = (state_q == M_WRESP);
  assign m_arvalid = (state_q == M_RADDR);
  assign m_rready  = (state_q == M_RDATA);

endmodule

// File: rtl/selftest_sequencer.sv
// Autonomous self-test pass over the test-top control map via AXI4-Lite.
// Define SELFTEST_DIO_EN to include the DIO programming and status read.
module selftest_sequencer
  import selftest_pkg::*;
#(
  parameter logic [31:0] POLL_TIMEOUT = 32'd50_000_000,
  parameter int unsigned POLL_GAP     = 16
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        start,
  input  logic [31:0] cfg_bram_addr_max,
  input  logic [31:0] cfg_bram_seed,
  input  logic [31:0] cfg_dio_counter_max,
  input  logic [31:0] cfg_dio_output_phase,
  input  logic [31:0] cfg_dio_settings,
  output logic        busy,
  output logic        done,
  output logic [2:0]  err_code,
  output logic [31:0] bram_status,
  output logic [31:0] dio_status,
  output logic [7:0]  m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [7:0]  m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready
);

  localparam logic [15:0] GAP_RELOAD = 16'(POLL_GAP);

  seq_state_t  state_q, state_d, step_d;
  err_t        err_q, err_new;
  logic        set_err;
  logic        pending_q;
  logic [15:0] gap_q;
  logic [31:0] tmo_q;
  logic [31:0] cfg_addr_max_q, cfg_seed_q, cfg_cmax_q, cfg_phase_q, cfg_settings_q;
  logic [31:0] bram_q, dio_q;

  logic        eng_req, eng_we, eng_ack;
  logic [7:0]  eng_addr;
  logic [31:0] eng_wdata, eng_rdata;
  logic [1:0]  eng_resp;

  logic        in_poll, is_write, is_xfer, timed_out, resp_ok, mask_hit;
  logic [31:0] poll_mask;

  assign in_poll   = (state_q == S_POLL_RDY) || (state_q == S_POLL_DONE);
  assign is_write  = (state_q == S_WR_ADDR_MAX) || (state_q == S_WR_SEED) ||
                     (state_q == S_WR_CMAX) || (state_q == S_WR_PHASE) ||
                     (state_q == S_WR_SETTINGS);
  assign is_xfer   = is_write || (state_q == S_RD_BRAM) || (state_q == S_RD_DIO);
  assign timed_out = (tmo_q >= POLL_TIMEOUT);
  assign resp_ok   = (eng_resp == RESP_OKAY);
  assign poll_mask = (state_q == S_POLL_RDY) ? RDY_MASK : DONE_MASK;
  assign mask_hit  = ((eng_rdata & poll_mask) == poll_mask);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // A poll read already in flight is allowed to finish (and may still succeed) before a timeout abort.
  always_comb begin
    state_d   = state_q;
    step_d    = S_IDLE;
    set_err   = 1'b0;
    err_new   = ERR_OK;
    eng_req   = 1'b0;
    eng_we    = 1'b0;
    eng_addr  = REG_CTRL_STATUS;
    eng_wdata = '0;
    case (state_q)
      S_IDLE: if (start) state_d = S_POLL_RDY;
      S_POLL_RDY, S_POLL_DONE: begin
        eng_req = !pending_q && (gap_q == '0) && !timed_out;
        if (eng_ack && !resp_ok) begin
          set_err = 1'b1;
          err_new = ERR_RRESP;
          state_d = S_FINISH;
        end else if (eng_ack && mask_hit) begin
          if (state_q == S_POLL_RDY) state_d = S_WR_ADDR_MAX;
          else                       state_d = S_RD_BRAM;
        end else if (timed_out && (eng_ack || !pending_q)) begin
          set_err = 1'b1;
          if (state_q == S_POLL_RDY) err_new = ERR_RDY_TMO;
          else                       err_new = ERR_DONE_TMO;
          state_d = S_FINISH;
        end
      end
      S_WR_ADDR_MAX: begin
        eng_addr  = REG_BRAM_ADDR_MAX;
        eng_wdata = cfg_addr_max_q;
        step_d    = S_WR_SEED;
      end
      S_WR_SEED: begin
        eng_addr  = REG_BRAM_SEED;
        eng_wdata = cfg_seed_q;
`ifdef SELFTEST_DIO_EN
        step_d    = S_WR_CMAX;
`else
        step_d    = S_POLL_DONE;
`endif
      end
      S_WR_CMAX: begin
        eng_addr  = REG_DIO_COUNTER_MAX;
        eng_wdata = cfg_cmax_q;
        step_d    = S_WR_PHASE;
      end
      S_WR_PHASE: begin
        eng_addr  = REG_DIO_OUTPUT_PHASE;
        eng_wdata = cfg_phase_q;
        step_d    = S_WR_SETTINGS;
      end
      S_WR_SETTINGS: begin
        eng_addr  = REG_DIO_SETTINGS;
        eng_wdata = cfg_settings_q;
        step_d    = S_POLL_DONE;
      end
      S_RD_BRAM: begin
        eng_addr = REG_BRAM_STATUS;
`ifdef SELFTEST_DIO_EN
        step_d   = S_RD_DIO;
`else
        step_d   = S_FINISH;
`endif
      end
      S_RD_DIO: begin
        eng_addr = REG_DIO_STATUS;
        step_d   = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (is_xfer) begin
      eng_req = !pending_q;
      eng_we  = is_write;
      if (eng_ack) begin
        if (!resp_ok) begin
          set_err = 1'b1;
          if (is_write) err_new = ERR_BRESP;
          else          err_new = ERR_RRESP;
          state_d = S_FINISH;
        end else begin
          state_d = step_d;
        end
      end
    end
  end

  // Gap and timeout counters restart on every state change; timeout saturates.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pending_q      <= 1'b0;
      gap_q          <= '0;
      tmo_q          <= '0;
      cfg_addr_max_q <= '0;
      cfg_seed_q     <= '0;
      cfg_cmax_q     <= '0;
      cfg_phase_q    <= '0;
      cfg_settings_q <= '0;
      err_q          <= ERR_OK;
      bram_q         <= '0;
      dio_q          <= '0;
    end else begin
      if (eng_req)      pending_q <= 1'b1;
      else if (eng_ack) pending_q <= 1'b0;

      if (state_d != state_q) begin
        gap_q <= '0;
        tmo_q <= '0;
      end else begin
        if (eng_ack)                        gap_q <= GAP_RELOAD;
        else if (!pending_q && gap_q != '0) gap_q <= gap_q - 16'd1;
        if (in_poll && tmo_q != '1)         tmo_q <= tmo_q + 32'd1;
      end

      if (state_q == S_IDLE && start) begin
        cfg_addr_max_q <= cfg_bram_addr_max;
        cfg_seed_q     <= cfg_bram_seed;
        cfg_cmax_q     <= cfg_dio_counter_max;
        cfg_phase_q    <= cfg_dio_output_phase;
        cfg_settings_q <= cfg_dio_settings;
        err_q          <= ERR_OK;
        bram_q         <= '0;
        dio_q          <= '0;
      end

      if (set_err) err_q <= err_new;
      if (eng_ack && resp_ok && state_q == S_RD_BRAM) bram_q <= eng_rdata;
      if (eng_ack && resp_ok && state_q == S_RD_DIO)  dio_q  <= eng_rdata;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FINISH);
  assign err_code    = err_q;
  assign bram_status = bram_q;
  assign dio_status  = dio_q;

  axil_single_master u_master (
    .clk       (clk),
    .aresetn   (aresetn),
    .req       (eng_req),
    .we        (eng_we),
    .addr      (eng_addr),
    .wdata     (eng_wdata),
    .ack       (eng_ack),
    .rdata     (eng_rdata),
    .resp      (eng_resp),
    .m_awaddr  (m_awaddr),
    .m_awvalid (m_awvalid),
    .m_awready (m_awready),
    .m_wdata   (m_wdata),
    .m_wvalid  (m_wvalid),
    .m_wready  (m_wready),
    .m_bresp   (m_bresp),
    .m_bvalid  (m_bvalid),
    .m_bready  (m_bready),
    .m_araddr  (m_araddr),
    .m_arvalid (m_arvalid),
    .m_arready (m_arready),
    .m_rdata   (m_rdata),
    .m_rresp   (m_rresp),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready)
  );

endmodule

// File: doc/selftest_sequencer.md
Name: selftest_sequencer

Overview:
- Autonomous AXI4-Lite master that runs one hardware self-test pass over the 8-bit control register map of the test top level.
- Sequence: wait for the test blocks to report ready, program the BRAM and DIO tests, poll for completion, then capture the status words.
- Sits beside the MicroBlaze master at the control slave port and reports a pass/fail summary for LEDs or software.

Parameters:
- POLL_TIMEOUT, 32'd50_000_000: maximum cycles spent in any single poll phase before aborting.
- POLL_GAP, 16: idle cycles between consecutive STATUS reads while polling (minimum 1).

Ports:
- clk  in  1  system clock
- aresetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; ignored unless idle
- cfg_bram_addr_max  in  32  value written to reg 28
- cfg_bram_seed  in  32  value written to reg 24
- cfg_dio_counter_max  in  32  value written to reg 36
- cfg_dio_output_phase  in  32  value written to reg 40
- cfg_dio_settings  in  32  value written to reg 12
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse at the end of a pass
- err_code  out  3  0 ok, 1 bresp≠OKAY, 2 rresp≠OKAY, 3 ready timeout, 4 completion timeout
- bram_status  out  32  word read from reg 32
- dio_status  out  32  word read from reg 16
- m_awaddr/awvalid/awready, m_wdata/wvalid/wready, m_bresp/bvalid/bready, m_araddr/arvalid/arready, m_rdata/rresp/rvalid/rready  AXI4-Lite master; addr 8, data 32, resp 2

Behaviour:
- Reset (async, aresetn low): all outputs 0; all valid/ready outputs low; sequencer IDLE.
- cfg_* sampled into registers on the accepted start; later changes do not affect the pass.
- Write transaction: assert awvalid and wvalid in the same cycle. Each valid drops independently on its own handshake. bready stays high until bvalid. bresp≠0 → abort, err 1.
- Read transaction: arvalid until arready, then rready high until rvalid. rresp≠0 → abort, err 2.
- Only one outstanding transaction at a time; strobe fixed, no wstrb port.
- States:
  - IDLE → POLL_RDY on start.
  - POLL_RDY: read reg 0 until (rdata & 0x1A4)==0x1A4, i.e. bits 2, 5, 7 and 8 set.
  - WR_ADDR_MAX(28) → WR_SEED(24) → WR_CMAX(36) → WR_PHASE(40) → WR_SETTINGS(12).
  - POLL_DONE: read reg 0 until (rdata & 0x048)==0x048, i.e. bits 3 and 6.
  - RD_BRAM(32) → RD_DIO(16) → FINISH → IDLE.
- Poll timing: POLL_GAP idle cycles between reads. The timeout counter clears on entry to each poll state and counts every cycle. Reaching POLL_TIMEOUT → abort, err 3 (POLL_RDY) or err 4 (POLL_DONE). A read that is in flight completes before the abort.
- Abort goes to FINISH.
- FINISH: done=1 for one cycle, busy=0 the next cycle; err_code, bram_status and dio_status hold until the next start.
- On start, err_code and both status outputs clear to 0.
- Start while busy: ignored, no queueing.
- Reset mid-transaction: valids drop immediately, with no completion; the slave must also be reset.
- The 32-bit timeout counter saturates and never wraps.

Optional Feature:
- SELFTEST_DIO_EN defined: full sequence as above.
- Undefined: WR_CMAX, WR_PHASE, WR_SETTINGS and RD_DIO are skipped; poll masks become 0x020 (ready) and 0x040 (done); dio_status stays 0.

Decomposition:
- Package selftest_pkg holds:
  - the register address constants 0…40;
  - the status mask constants;
  - the state enum;
  - the err_code enum;
  - the resp_t OKAY constant.
- Sub-module axil_single_master: a single-transaction engine.
  - Inputs: req, we, addr, wdata.
  - Outputs: ack pulse, rdata, resp.
  - Owns all AXI handshaking.
  - The sequencer owns only stepping and polling.

Test Plan:
- Slave responds in 0 wait states, status 0x1A4 then 0x048 after 3 polls, bram=0x0000_0001, dio=0x0000_00AB → five writes in order 28,24,36,40,12 with the cfg data; done pulses once; err 0; outputs 0x1, 0xAB.
- Slave asserts awready 4 cycles before wready, and vice versa → each valid drops on its own handshake, exactly one bvalid consumed per write, no duplicate writes.
- Status never shows bit 6, POLL_TIMEOUT=1000 → done about 1000 cycles after POLL_DONE entry; err 4; no reads of 32/16.
- bresp=2'b10 on the reg-24 write → abort; err 1; no writes to 36/40/12.
- aresetn pulsed low while arvalid is high → arvalid low asynchronously; busy 0; a later start runs a clean full pass.
- Build without SELFTEST_DIO_EN → only writes 28,24 and reads 0…,32; dio_status 0.
